// File: rtl/fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : fwd_scoreboard
// Description : Operand forwarding and load-use hazard unit. Tracks in-flight
//               destination registers over DEPTH post-decode stages, captures
//               producer results as they appear and serves the youngest
//               matching value to each decode-stage source operand.
//               Optional stall-cycle counter enabled by macro FWD_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module fwd_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int RA_W     = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              issue_valid,
    input  logic              issue_we,
    input  logic              issue_is_load,
    input  logic [RA_W-1:0]   issue_rd,
    input  logic [RA_W-1:0]   rs1,
    input  logic [RA_W-1:0]   rs2,
    input  logic              rs1_used,
    input  logic              rs2_used,
    input  logic [DATA_W-1:0] exec_result,
    input  logic [DATA_W-1:0] load_data,
    input  logic              flush,
    output logic              stall,
    output logic              op1_fwd,
    output logic              op2_fwd,
    output logic [DATA_W-1:0] op1_data,
    output logic [DATA_W-1:0] op2_data,
    output logic [15:0]       stall_cnt
);

    localparam int c_NUM_OPS = 2;

    // Per-stage entry state; index 0 is EX, DEPTH-1 is the last stage before writeback
    logic              r_v    [DEPTH];
    logic [RA_W-1:0]   r_rd   [DEPTH];
    logic              r_ld   [DEPTH];
    logic              r_rdy  [DEPTH];
    logic [DATA_W-1:0] r_data [DEPTH];

    logic [RA_W-1:0]   w_rs    [c_NUM_OPS];
    logic              w_used  [c_NUM_OPS];
    logic              w_en    [c_NUM_OPS];
    logic              w_hit   [c_NUM_OPS];
    logic              w_avail [c_NUM_OPS];
    logic [DATA_W-1:0] w_val   [c_NUM_OPS];
    logic              w_fwd   [c_NUM_OPS];
    logic [DATA_W-1:0] w_data  [c_NUM_OPS];
    logic              w_unav  [c_NUM_OPS];
    logic              w_stall;

    assign w_rs[0]   = rs1;
    assign w_rs[1]   = rs2;
    assign w_used[0] = rs1_used;
    assign w_used[1] = rs2_used;

    // Youngest-match lookup per operand; scanning oldest to youngest lets the lowest stage win
    always_comb begin
        for (int j = 0; j < c_NUM_OPS; j++) begin
            w_hit[j]   = 1'b0;
            w_avail[j] = 1'b0;
            w_val[j]   = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (r_v[k] && (r_rd[k] == w_rs[j])) begin
                    w_hit[j] = 1'b1;
                    if (!r_ld[k] && (k == 0)) begin
                        // ALU result is still on the EX bus this cycle
                        w_avail[j] = 1'b1;
                        w_val[j]   = exec_result;
                    end else if (r_ld[k] && (k == LOAD_LAT)) begin
                        // Load data is arriving this cycle
                        w_avail[j] = 1'b1;
                        w_val[j]   = load_data;
                    end else if (r_rdy[k]) begin
                        w_avail[j] = 1'b1;
                        w_val[j]   = r_data[k];
                    end else begin
                        // Load that has not yet reached its data stage
                        w_avail[j] = 1'b0;
                        w_val[j]   = '0;
                    end
                end
            end
            w_en[j]   = issue_valid && w_used[j] && (w_rs[j] != '0);
            w_fwd[j]  = w_en[j] && w_hit[j] && w_avail[j];
            w_data[j] = w_fwd[j] ? w_val[j] : '0;
            w_unav[j] = w_en[j] && w_hit[j] && !w_avail[j];
        end
    end

    // A flush in the same cycle discards decode, so there is nothing to hold
    assign w_stall  = !flush && (w_unav[0] || w_unav[1]);
    assign stall    = w_stall;
    assign op1_fwd  = w_fwd[0];
    assign op2_fwd  = w_fwd[1];
    assign op1_data = w_data[0];
    assign op2_data = w_data[1];

    // Advance the tracking pipeline, capturing results as entries leave their producing stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_v[k]    <= 1'b0;
                r_rd[k]   <= '0;
                r_ld[k]   <= 1'b0;
                r_rdy[k]  <= 1'b0;
                r_data[k] <= '0;
            end
        end else begin
            r_v[0]    <= issue_valid && issue_we && !w_stall && !flush && (issue_rd != '0);
            r_rd[0]   <= issue_rd;
            r_ld[0]   <= issue_is_load;
            r_rdy[0]  <= 1'b0;
            r_data[0] <= '0;
            for (int k = 1; k < DEPTH; k++) begin
                r_v[k]  <= r_v[k-1] && !flush;
                r_rd[k] <= r_rd[k-1];
                r_ld[k] <= r_ld[k-1];
                if (r_v[k-1] && !r_ld[k-1] && ((k - 1) == 0)) begin
                    r_data[k] <= exec_result;
                    r_rdy[k]  <= 1'b1;
                end else if (r_v[k-1] && r_ld[k-1] && ((k - 1) == LOAD_LAT)) begin
                    r_data[k] <= load_data;
                    r_rdy[k]  <= 1'b1;
                end else begin
                    r_data[k] <= r_data[k-1];
                    r_rdy[k]  <= r_rdy[k-1];
                end
            end
        end
    end

`ifdef FWD_STATS_EN
    logic [15:0] r_stall_cnt;

    // Saturating count of stalled decode cycles; only reset clears it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fwd_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_fwd_scoreboard
// Description : Self-checking bench for fwd_scoreboard (DEPTH=3, LOAD_LAT=1).
//               Each cycle's expected outputs are queued as stimulus is
//               driven and popped when the outputs are sampled.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fwd_scoreboard;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        issue_valid, issue_we, issue_is_load;
    logic [4:0]  issue_rd, rs1, rs2;
    logic        rs1_used, rs2_used;
    logic [31:0] exec_result, load_data;
    logic        flush;
    logic        stall, op1_fwd, op2_fwd;
    logic [31:0] op1_data, op2_data;
    logic [15:0] stall_cnt;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_cnt = 0;

    typedef struct {
        logic        iv, iwe, ild;
        logic [4:0]  ird, rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [31:0] ex, ldd;
        logic        fl;
        logic        f1;
        logic [31:0] d1;
        logic        f2;
        logic [31:0] d2;
        logic        st;
    } cyc_t;

    cyc_t sb[$];

    fwd_scoreboard dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_we     (issue_we),
        .issue_is_load(issue_is_load),
        .issue_rd     (issue_rd),
        .rs1          (rs1),
        .rs2          (rs2),
        .rs1_used     (rs1_used),
        .rs2_used     (rs2_used),
        .exec_result  (exec_result),
        .load_data    (load_data),
        .flush        (flush),
        .stall        (stall),
        .op1_fwd      (op1_fwd),
        .op2_fwd      (op2_fwd),
        .op1_data     (op1_data),
        .op2_data     (op2_data),
        .stall_cnt    (stall_cnt)
    );

    always #5 clk = ~clk;

    function automatic cyc_t mk(int iv, int iwe, int ild, int ird, int r1, int u1, int r2, int u2,
                                logic [31:0] ex, logic [31:0] ldd, int fl,
                                int f1, logic [31:0] d1, int f2, logic [31:0] d2, int st);
        cyc_t c;
        c.iv = (iv != 0); c.iwe = (iwe != 0); c.ild = (ild != 0);
        c.ird = 5'(ird); c.rs1 = 5'(r1); c.u1 = (u1 != 0);
        c.rs2 = 5'(r2); c.u2 = (u2 != 0);
        c.ex = ex; c.ldd = ldd; c.fl = (fl != 0);
        c.f1 = (f1 != 0); c.d1 = d1; c.f2 = (f2 != 0); c.d2 = d2; c.st = (st != 0);
        return c;
    endfunction

    // Expected counter value: stalls seen so far when stats are built in, else always zero
    function automatic logic [15:0] want_cnt();
`ifdef FWD_STATS_EN
        return 16'(exp_cnt);
`else
        return 16'd0;
`endif
    endfunction

    // Drive one cycle of stimulus and queue its expected outputs
    task automatic apply(input cyc_t c);
        issue_valid = c.iv; issue_we = c.iwe; issue_is_load = c.ild; issue_rd = c.ird;
        rs1 = c.rs1; rs1_used = c.u1; rs2 = c.rs2; rs2_used = c.u2;
        exec_result = c.ex; load_data = c.ldd; flush = c.fl;
        sb.push_back(c);
    endtask

    task automatic idle(input int n);
        issue_valid = 0; issue_we = 0; issue_is_load = 0; issue_rd = 0;
        rs1 = 0; rs1_used = 0; rs2 = 0; rs2_used = 0;
        exec_result = 0; load_data = 0; flush = 0;
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle(3);
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall got %0b want 0", stall); end
        n_chk++; if (op1_fwd !== 1'b0) begin n_fail++; $display("FAIL reset op1_fwd got %0b want 0", op1_fwd); end
        n_chk++; if (op2_fwd !== 1'b0) begin n_fail++; $display("FAIL reset op2_fwd got %0b want 0", op2_fwd); end
        n_chk++; if (op1_data !== 32'd0) begin n_fail++; $display("FAIL reset op1_data got %h want 0", op1_data); end
        n_chk++; if (op2_data !== 32'd0) begin n_fail++; $display("FAIL reset op2_data got %h want 0", op2_data); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL reset stall_cnt got %0d want 0", stall_cnt); end
        rst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_alu_fwd();
        cyc_t t[$]; cyc_t e;
        t.push_back(mk(1,1,0,3, 0,0,0,0, 0,0,0,         0,0,0,0,0));
        t.push_back(mk(1,0,0,0, 3,1,0,0, 'h55,0,0,      1,'h55,0,0,0));
        t.push_back(mk(1,0,0,0, 3,1,3,1, 'h99,0,0,      1,'h55,1,'h55,0));
        t.push_back(mk(1,0,0,0, 3,0,3,1, 'h77,0,0,      0,0,1,'h55,0));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #4; e = sb.pop_front();
            n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL alu[%0d] stall got %0b want %0b", i, stall, e.st); end
            n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL alu[%0d] op1_fwd got %0b want %0b", i, op1_fwd, e.f1); end
            n_chk++; if (op1_data !== e.d1) begin n_fail++; $display("FAIL alu[%0d] op1_data got %h want %h", i, op1_data, e.d1); end
            n_chk++; if (op2_fwd !== e.f2) begin n_fail++; $display("FAIL alu[%0d] op2_fwd got %0b want %0b", i, op2_fwd, e.f2); end
            n_chk++; if (op2_data !== e.d2) begin n_fail++; $display("FAIL alu[%0d] op2_data got %h want %h", i, op2_data, e.d2); end
            n_chk++; if (stall_cnt !== want_cnt()) begin n_fail++; $display("FAIL alu[%0d] stall_cnt got %0d want %0d", i, stall_cnt, want_cnt()); end
            if (e.st) exp_cnt++;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_load_use();
        cyc_t t[$]; cyc_t e;
        t.push_back(mk(1,1,1,5,  0,0,0,0,   0,0,0,              0,0,0,0,0));
        t.push_back(mk(1,1,0,8,  0,0,5,1,   0,'h1234,0,         0,0,0,0,1));
        t.push_back(mk(1,1,0,8,  0,0,5,1,   0,'hDEADBEEF,0,     0,0,1,'hDEADBEEF,0));
        t.push_back(mk(1,0,0,0,  5,1,8,1,   'h88,0,0,           1,'hDEADBEEF,1,'h88,0));
        t.push_back(mk(1,1,1,10, 0,0,0,0,   0,0,0,              0,0,0,0,0));
        t.push_back(mk(1,0,0,0,  10,1,10,1, 0,'h5,0,            0,0,0,0,1));
        t.push_back(mk(1,0,0,0,  10,1,10,1, 0,'hCAFE,0,         1,'hCAFE,1,'hCAFE,0));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #4; e = sb.pop_front();
            n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL load[%0d] stall got %0b want %0b", i, stall, e.st); end
            n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL load[%0d] op1_fwd got %0b want %0b", i, op1_fwd, e.f1); end
            n_chk++; if (op1_data !== e.d1) begin n_fail++; $display("FAIL load[%0d] op1_data got %h want %h", i, op1_data, e.d1); end
            n_chk++; if (op2_fwd !== e.f2) begin n_fail++; $display("FAIL load[%0d] op2_fwd got %0b want %0b", i, op2_fwd, e.f2); end
            n_chk++; if (op2_data !== e.d2) begin n_fail++; $display("FAIL load[%0d] op2_data got %h want %h", i, op2_data, e.d2); end
            n_chk++; if (stall_cnt !== want_cnt()) begin n_fail++; $display("FAIL load[%0d] stall_cnt got %0d want %0d", i, stall_cnt, want_cnt()); end
            if (e.st) exp_cnt++;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_youngest();
        cyc_t t[$]; cyc_t e;
        t.push_back(mk(1,1,0,7, 0,0,0,0, 0,0,0,      0,0,0,0,0));
        t.push_back(mk(1,1,0,7, 0,0,0,0, 'h11,0,0,   0,0,0,0,0));
        t.push_back(mk(1,0,0,0, 7,1,0,0, 'h22,0,0,   1,'h22,0,0,0));
        t.push_back(mk(1,0,0,0, 7,1,7,1, 'h33,0,0,   1,'h22,1,'h22,0));
        t.push_back(mk(1,1,1,7, 0,0,0,0, 0,0,0,      0,0,0,0,0));
        t.push_back(mk(1,0,0,0, 7,1,0,0, 0,'h66,0,   0,0,0,0,1));
        t.push_back(mk(1,0,0,0, 7,1,0,0, 0,'h77,0,   1,'h77,0,0,0));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #4; e = sb.pop_front();
            n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL young[%0d] stall got %0b want %0b", i, stall, e.st); end
            n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL young[%0d] op1_fwd got %0b want %0b", i, op1_fwd, e.f1); end
            n_chk++; if (op1_data !== e.d1) begin n_fail++; $display("FAIL young[%0d] op1_data got %h want %h", i, op1_data, e.d1); end
            n_chk++; if (op2_fwd !== e.f2) begin n_fail++; $display("FAIL young[%0d] op2_fwd got %0b want %0b", i, op2_fwd, e.f2); end
            n_chk++; if (op2_data !== e.d2) begin n_fail++; $display("FAIL young[%0d] op2_data got %h want %h", i, op2_data, e.d2); end
            n_chk++; if (stall_cnt !== want_cnt()) begin n_fail++; $display("FAIL young[%0d] stall_cnt got %0d want %0d", i, stall_cnt, want_cnt()); end
            if (e.st) exp_cnt++;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_r0_retire();
        cyc_t t[$]; cyc_t e;
        t.push_back(mk(1,1,0,0, 0,1,0,1, 'h5,0,0,   0,0,0,0,0));
        t.push_back(mk(1,0,0,0, 0,1,0,1, 'h6,0,0,   0,0,0,0,0));
        t.push_back(mk(1,1,0,4, 0,0,0,0, 0,0,0,     0,0,0,0,0));
        t.push_back(mk(0,0,0,0, 0,0,0,0, 'h44,0,0,  0,0,0,0,0));
        t.push_back(mk(0,0,0,0, 4,1,0,0, 0,0,0,     0,0,0,0,0));
        t.push_back(mk(1,0,0,0, 4,1,0,0, 0,0,0,     1,'h44,0,0,0));
        t.push_back(mk(1,0,0,0, 4,1,4,1, 0,0,0,     0,0,0,0,0));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #4; e = sb.pop_front();
            n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL r0ret[%0d] stall got %0b want %0b", i, stall, e.st); end
            n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL r0ret[%0d] op1_fwd got %0b want %0b", i, op1_fwd, e.f1); end
            n_chk++; if (op1_data !== e.d1) begin n_fail++; $display("FAIL r0ret[%0d] op1_data got %h want %h", i, op1_data, e.d1); end
            n_chk++; if (op2_fwd !== e.f2) begin n_fail++; $display("FAIL r0ret[%0d] op2_fwd got %0b want %0b", i, op2_fwd, e.f2); end
            n_chk++; if (op2_data !== e.d2) begin n_fail++; $display("FAIL r0ret[%0d] op2_data got %h want %h", i, op2_data, e.d2); end
            if (e.st) exp_cnt++;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_flush();
        cyc_t t[$]; cyc_t e;
        t.push_back(mk(1,1,0,11, 0,0,0,0,  0,0,0,         0,0,0,0,0));
        t.push_back(mk(1,1,1,6,  0,0,0,0,  'h1111,0,0,   0,0,0,0,0));
        t.push_back(mk(1,1,0,9,  6,1,0,0,  0,0,1,         0,0,0,0,0));
        t.push_back(mk(1,0,0,0,  6,1,11,1, 'h5,'hBAD,0,   0,0,0,0,0));
        t.push_back(mk(1,0,0,0,  9,1,0,0,  0,0,0,         0,0,0,0,0));
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #4; e = sb.pop_front();
            n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL flush[%0d] stall got %0b want %0b", i, stall, e.st); end
            n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL flush[%0d] op1_fwd got %0b want %0b", i, op1_fwd, e.f1); end
            n_chk++; if (op2_fwd !== e.f2) begin n_fail++; $display("FAIL flush[%0d] op2_fwd got %0b want %0b", i, op2_fwd, e.f2); end
            n_chk++; if (op2_data !== e.d2) begin n_fail++; $display("FAIL flush[%0d] op2_data got %h want %h", i, op2_data, e.d2); end
            n_chk++; if (stall_cnt !== want_cnt()) begin n_fail++; $display("FAIL flush[%0d] stall_cnt got %0d want %0d", i, stall_cnt, want_cnt()); end
            if (e.st) exp_cnt++;
            @(posedge clk); #1;
        end
        idle(4);
    endtask

    task automatic test_stats();
        cyc_t t[$]; cyc_t e;
        int base;
        base = exp_cnt;
        for (int r = 13; r <= 15; r++) begin
            t.push_back(mk(1,1,1,r, 0,0,0,0, 0,0,0,            0,0,0,0,0));
            t.push_back(mk(1,0,0,0, r,1,0,0, 0,'h1,0,          0,0,0,0,1));
            t.push_back(mk(1,0,0,0, r,1,0,0, 0,32'(r * 'h101),0, 1,32'(r * 'h101),0,0,0));
        end
        for (int i = 0; i < t.size(); i++) begin
            apply(t[i]); #4; e = sb.pop_front();
            n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL stats[%0d] stall got %0b want %0b", i, stall, e.st); end
            n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL stats[%0d] op1_fwd got %0b want %0b", i, op1_fwd, e.f1); end
            n_chk++; if (op1_data !== e.d1) begin n_fail++; $display("FAIL stats[%0d] op1_data got %h want %h", i, op1_data, e.d1); end
            if (e.st) exp_cnt++;
            @(posedge clk); #1;
        end
        n_chk++;
        if (stall_cnt !== want_cnt()) begin
            n_fail++; $display("FAIL stats total stall_cnt got %0d want %0d (3 new stalls over %0d)", stall_cnt, want_cnt(), base);
        end
        idle(4);
    endtask

    task automatic test_reset_mid_stall();
        cyc_t e;
        apply(mk(1,1,1,20, 0,0,0,0, 0,0,0, 0,0,0,0,0));
        e = sb.pop_front();
        @(posedge clk); #1;
        apply(mk(1,1,0,21, 20,1,0,0, 0,0,0, 0,0,0,0,1));
        #4; e = sb.pop_front();
        n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL rststall pre stall got %0b want %0b", stall, e.st); end
        rst_n = 1'b0;
        #1;
        exp_cnt = 0;
        n_chk++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rststall async stall got %0b want 0", stall); end
        n_chk++; if (stall_cnt !== 16'd0) begin n_fail++; $display("FAIL rststall async stall_cnt got %0d want 0", stall_cnt); end
        n_chk++; if (op1_fwd !== 1'b0) begin n_fail++; $display("FAIL rststall async op1_fwd got %0b want 0", op1_fwd); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply(mk(1,0,0,0, 20,1,21,1, 'h9,'h9,0, 0,0,0,0,0));
        #4; e = sb.pop_front();
        n_chk++; if (stall !== e.st) begin n_fail++; $display("FAIL rststall post stall got %0b want %0b", stall, e.st); end
        n_chk++; if (op1_fwd !== e.f1) begin n_fail++; $display("FAIL rststall post op1_fwd got %0b want %0b", op1_fwd, e.f1); end
        n_chk++; if (op2_fwd !== e.f2) begin n_fail++; $display("FAIL rststall post op2_fwd got %0b want %0b", op2_fwd, e.f2); end
        n_chk++; if (stall_cnt !== want_cnt()) begin n_fail++; $display("FAIL rststall post stall_cnt got %0d want %0d", stall_cnt, want_cnt()); end
        @(posedge clk); #1;
        idle(2);
    endtask

    initial begin
        rst_n = 1'b0;
        idle(1);
        test_reset();
        test_alu_fwd();
        test_load_use();
        test_youngest();
        test_r0_retire();
        test_flush();
        test_stats();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
